// File: rtl/rvga_types.sv
// Shared types for the rvga core and its SoC-side memory models.
// Word type, data-memory responder states and LFSR seed.
package rvga_types;

   typedef logic [31:0] rvga_word;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } rvga_dmem_state_e;

   localparam logic [3:0] RVGA_DMEM_LFSR_SEED = 4'b1001;

endpackage

// File: rtl/rvga_lfsr4.sv
// 4-bit Fibonacci LFSR, polynomial x^4+x^3+1, steps once per advance.
// Ports: clk_i, rst_i (sync, active-high), advance_i in; state_o out.
module rvga_lfsr4
   import rvga_types::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       advance_i,
   output logic [3:0] state_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_o <= RVGA_DMEM_LFSR_SEED;
      end else if (advance_i) begin
         state_o <= {state_o[2:0], state_o[3] ^ state_o[2]};
      end
   end

endmodule

// File: rtl/rvga_dmem_responder.sv
// Data-memory responder: word array, one request at a time, fixed or
// LFSR-jittered latency (macro RVGA_DMEM_RAND_LAT_EN), 1-cycle resp pulse.
// Ports: clk_i, rst_i (sync, active-high), dmem_r_v_i, dmem_w_v_i,
//        dmem_addr_i, dmem_data_i in; dmem_data_o, dmem_resp_v_o out.
module rvga_dmem_responder
   import rvga_types::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     dmem_r_v_i,
   input  logic     dmem_w_v_i,
   input  rvga_word dmem_addr_i,
   input  rvga_word dmem_data_i,
   output rvga_word dmem_data_o,
   output logic     dmem_resp_v_o
);

   localparam int IW = $clog2(DEPTH_WORDS);

   rvga_dmem_state_e state;
   logic [3:0]       cnt;
   logic [IW-1:0]    idx;
   rvga_word         wdata;
   logic             op_w;

   rvga_word         mem [DEPTH_WORDS];

   logic             accept;
   logic             go_resp;
   logic [3:0]       eff_lat;
   logic [IW-1:0]    c_idx;
   rvga_word         c_data;
   logic             c_w;

   assign accept = (state == IDLE) && (dmem_r_v_i || dmem_w_v_i);

`ifdef RVGA_DMEM_RAND_LAT_EN
   logic [3:0] lfsr;
   logic [4:0] lat_sum;

   rvga_lfsr4 u_lfsr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .advance_i (accept),
      .state_o   (lfsr)
   );

   // Jitter uses the pre-advance LFSR value; sum saturates at 15.
   assign lat_sum = 5'(LATENCY) + {3'b000, lfsr[1:0]};
   assign eff_lat = (lat_sum > 5'd15) ? 4'd15 : lat_sum[3:0];

   logic unused_lfsr;
   assign unused_lfsr = ^lfsr[3:2];
`else
   assign eff_lat = 4'(LATENCY);
`endif

   // With latency 1 the commit happens on the accepting edge, so the
   // operands come straight from the inputs rather than the capture regs.
   assign c_idx  = (state == IDLE) ? dmem_addr_i[IW+1:2] : idx;
   assign c_data = (state == IDLE) ? dmem_data_i : wdata;
   assign c_w    = (state == IDLE) ? dmem_w_v_i : op_w;

   assign go_resp = (accept && (eff_lat == 4'd1)) ||
                    ((state == BUSY) && (cnt == 4'd0));

   // Array has no reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && go_resp && c_w) begin
         mem[c_idx] <= c_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         idx           <= '0;
         wdata         <= '0;
         op_w          <= 1'b0;
         dmem_resp_v_o <= 1'b0;
         dmem_data_o   <= '0;
      end else begin
         dmem_resp_v_o <= 1'b0;
         if (go_resp) begin
            dmem_resp_v_o <= 1'b1;
            dmem_data_o   <= c_w ? c_data : mem[c_idx];
         end
         unique case (state)
            IDLE: begin
               if (accept) begin
                  idx   <= dmem_addr_i[IW+1:2];
                  wdata <= dmem_data_i;
                  op_w  <= dmem_w_v_i;
                  if (eff_lat == 4'd1) begin
                     state <= RESP;
                  end else begin
                     state <= BUSY;
                     cnt   <= 4'(eff_lat - 4'd2);
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic unused_addr;
   assign unused_addr = ^{dmem_addr_i[31:IW+2], dmem_addr_i[1:0]};

endmodule

// File: tb/tb_rvga_dmem_responder.sv
// Self-checking bench for rvga_dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
// Reference: word-array model plus latency model (LFSR under the macro).
module tb_rvga_dmem_responder;

   localparam int LAT = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_v;
   logic        w_v;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        resp;

   int errors = 0;
   int checks = 0;

   logic [31:0] mmem   [DEPTH];
   bit          mvalid [DEPTH];
   int          mlfsr;

   always #5 clk = ~clk;

   rvga_dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .dmem_r_v_i    (r_v),
      .dmem_w_v_i    (w_v),
      .dmem_addr_i   (addr),
      .dmem_data_i   (wd),
      .dmem_data_o   (rd),
      .dmem_resp_v_o (resp)
   );

   // Expected latency of the next accepted request; steps the model LFSR.
   task automatic model_lat(output int l);
`ifdef RVGA_DMEM_RAND_LAT_EN
      int fb;
      l = LAT + (mlfsr % 4);
      if (l > 15) l = 15;
      fb = ((mlfsr / 8) + (mlfsr / 4)) % 2;
      mlfsr = ((mlfsr * 2) % 16) + fb;
`else
      l = LAT;
`endif
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // One transaction, held until the pulse; returns observed latency,
   // read data and resp_v one cycle after the pulse.
   task automatic do_req(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit drop,
                         output int lat, output int exp_lat,
                         output logic [31:0] q, output logic after);
      model_lat(exp_lat);
      @(negedge clk);
      r_v = r; w_v = w; addr = a; wd = d;
      lat = -1; q = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (resp) begin
            lat = n; q = rd;
            break;
         end
         if (drop) begin
            r_v = 1'b0; w_v = 1'b0;
            addr = $urandom; wd = $urandom;
         end
      end
      r_v = 1'b0; w_v = 1'b0;
      @(posedge clk); #1;
      after = resp;
      if (w) begin
         mmem[widx(a)] = d;
         mvalid[widx(a)] = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; r_v = 1'b0; w_v = 1'b0; addr = '0; wd = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (resp !== 1'b0) begin
         errors++; $display("FAIL reset_resp got=%b want=0", resp);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL reset_data got=%h want=0", rd);
      end
      @(negedge clk);
      rst = 1'b0;
      mlfsr = 9;
   endtask

   task automatic test_read_latency;
      int lat, el; logic [31:0] q; logic af;
      do_req(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, lat, el, q, af);
      do_req(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (lat != el) begin
         errors++; $display("FAIL rd_lat got=%0d want=%0d", lat, el);
      end
      checks++;
      if (q !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_data got=%h want=deadbeef", q);
      end
      checks++;
      if (af !== 1'b0) begin
         errors++; $display("FAIL rd_pulse got=%b want=0", af);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_hold got=%h want=deadbeef", rd);
      end
   endtask

   task automatic test_write_read;
      int lat, el; logic [31:0] q; logic af;
      do_req(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, lat, el, q, af);
      checks++;
      if (lat != el || af !== 1'b0) begin
         errors++; $display("FAIL wr_pulse lat=%0d want=%0d after=%b", lat, el, af);
      end
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'h12345678 || lat != el || af !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd got=%h lat=%0d want=12345678 lat=%0d", q, lat, el);
      end
   endtask

   task automatic test_simultaneous;
      int lat, el; logic [31:0] q; logic af;
      do_req(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'hA5A5A5A5 || lat != el) begin
         errors++; $display("FAIL both got=%h lat=%0d want=a5a5a5a5 lat=%0d", q, lat, el);
      end
      do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL both_rd got=%h want=a5a5a5a5", q);
      end
   endtask

   task automatic test_alias;
      int lat, el; logic [31:0] q; logic af;
      do_req(1'b0, 1'b1, 32'h0000_1000, 32'h1, 1'b0, lat, el, q, af);
      do_req(1'b1, 1'b0, 32'h0000_0003, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'h1) begin
         errors++; $display("FAIL alias got=%h want=1", q);
      end
   endtask

   task automatic test_drop_during_busy;
      int lat, el; logic [31:0] q; logic af;
      do_req(1'b0, 1'b1, 32'h80, 32'hCAFE0001, 1'b1, lat, el, q, af);
      checks++;
      if (lat != el) begin
         errors++; $display("FAIL drop_lat got=%0d want=%0d", lat, el);
      end
      do_req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'hCAFE0001) begin
         errors++; $display("FAIL drop_data got=%h want=cafe0001", q);
      end
   endtask

   task automatic test_reset_mid_op;
      int lat, el, seen; logic [31:0] q; logic af;
      do_req(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1'b0, lat, el, q, af);
      @(negedge clk);
      w_v = 1'b1; addr = 32'h10; wd = 32'h0000FFFF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL rst_mid resp=%b data=%h want=0/0", resp, rd);
      end
      @(negedge clk);
      rst = 1'b0; w_v = 1'b0;
      mlfsr = 9;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (resp) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rst_noresp got=%0d pulses want=0", seen);
      end
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, el, q, af);
      checks++;
      if (q !== 32'h0BADF00D || lat != el) begin
         errors++; $display("FAIL rst_keep got=%h lat=%0d want=0badf00d lat=%0d", q, lat, el);
      end
   endtask

   task automatic test_random;
      int lat, el, op, ix; logic [31:0] a, d, q, exp; logic af; bit rr, ww;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         ix = $urandom_range(0, 15) * 4;
         a = ($urandom << 12) | (ix << 2) | $urandom_range(0, 3);
         d = $urandom;
         rr = (op != 1); ww = (op != 0);
         exp = ww ? d : mmem[widx(a)];
         do_req(rr, ww, a, d, 1'b0, lat, el, q, af);
         checks++;
         if (lat != el || af !== 1'b0) begin
            errors++;
            $display("FAIL rand_lat i=%0d got=%0d want=%0d after=%b", i, lat, el, af);
         end
         if (ww || mvalid[widx(a)]) begin
            checks++;
            if (q !== exp) begin
               errors++; $display("FAIL rand_data i=%0d got=%h want=%h", i, q, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_read();
      test_simultaneous();
      test_alias();
      test_drop_during_busy();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rvga_dmem_responder.md
# rvga_dmem_responder

Data-memory responder answering the core's data-cache interface (`dmem_r_v`/`dmem_w_v`/`dmem_addr`/`dmem_data`/`dmem_resp_v`). It holds a word-addressed storage array, accepts one level-held read or write request at a time, and returns a single-cycle response after a programmable latency. It sits outside `rvga_top` in the testbench/SoC wrapper and drives the core's memory-stage stall through `dmem_resp_v`.

## Interface
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words; power of two, at least 2.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `dmem_r_v_i`  in  1  read request, level-held by the core until the response.
- `dmem_w_v_i`  in  1  write request, level-held by the core until the response.
- `dmem_addr_i`  in  32  byte address; bits [1:0] ignored.
- `dmem_data_i`  in  32  write data from the core.
- `dmem_data_o`  out  32  read data; valid only while `dmem_resp_v_o`=1.
- `dmem_resp_v_o`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `r_v|w_v`, capture address index, write data and op in registers (request accepted).
  - If the effective latency is 1, go to RESP; otherwise go to BUSY with `cnt` = effective latency − 2.
- BUSY: if `cnt`==0, go to RESP; otherwise decrement `cnt`. The 4-bit counter never wraps.
- Commit on the edge entering RESP:
  - A write updates the array at the captured index.
  - A read registers the array word at the captured index into `dmem_data_o`.
- RESP: `dmem_resp_v_o`=1 for exactly this cycle, then always return to IDLE. A request still present in the RESP cycle is the old one and is never re-accepted.
- Index = `addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so the address space aliases (wraps).
- `r_v` and `w_v` asserted together: treated as a write; `dmem_data_o` returns the written data.
- A request deasserted during BUSY: the transaction still completes, the write still commits, and RESP still pulses. Input changes after acceptance are ignored.
- Reset (including mid-transaction):
  - State goes to IDLE; `dmem_resp_v_o`=0, `dmem_data_o`=0, `cnt`=0.
  - An in-flight write is aborted with no commit.
  - Array contents are not cleared.

## Timing
- Request first seen in IDLE at cycle t: response at cycle t+L, where L is the effective latency.
- Minimum spacing between accepted requests is L+1 cycles, because of the mandatory IDLE cycle after RESP.
- A write at cycle t is visible to a read accepted at cycle t+L+1 or later.
- `dmem_data_o` holds its value outside RESP cycles. Consumers must only sample it while `dmem_resp_v_o`=1.

## Configuration
- Macro: `RVGA_DMEM_RAND_LAT_EN`.
- Defined:
  - A 4-bit LFSR (taps x^4+x^3+1) is seeded to 4'b1001 on reset and advances once per accepted request.
  - Effective latency = `LATENCY` + `lfsr[1:0]` (range LATENCY..LATENCY+3), using the LFSR value before the advance.
  - Sum is saturated at 15.
- Undefined: effective latency = `LATENCY` exactly; no LFSR logic is present.

## Structure
- `rvga_types` package gets:
  - `rvga_dmem_state_e` (IDLE/BUSY/RESP);
  - `RVGA_DMEM_LFSR_SEED`.
- Existing `rvga_word` is used for the data and address ports.
- Sub-module `rvga_lfsr4`: clk/rst/advance in, 4-bit state out; instantiated only under the macro.
- Storage is an inferred `rvga_word` array with a registered read.

## Test plan
- Read latency: LATENCY=2, preload word 5 = 0xDEADBEEF, `r_v`=1 with addr 0x14 at cycle 0 -> `resp_v`=1 at cycle 2 only, data 0xDEADBEEF.
- Write then read: write 0x12345678 to 0x40, hold until response, idle one cycle, read 0x40 -> read data 0x12345678, two separate single-cycle pulses.
- Simultaneous request: `r_v`=`w_v`=1, addr 0x8, data 0xA5A5A5A5 -> `resp_v` at t+L with data 0xA5A5A5A5; a later read of 0x8 returns 0xA5A5A5A5.
- Alias and low bits: DEPTH_WORDS=1024, write 0x1 to 0x0000_1000, read 0x0000_0003 -> data 0x1.
- Reset mid-op: LATENCY=4, write 0xFFFF to 0x10, assert `rst_i` at t+2 -> no `resp_v`, `dmem_data_o`=0; a later read of 0x10 returns the prior value.
- Macro on: with LATENCY=1, 8 consecutive reads -> each response latency lies in 1..4 and matches the LFSR sequence from seed 4'b1001.
